pw_mac_accum_vec: RTL

- Pointwise (1x1) convolution MAC stage, directly downstream of the vectorised pointwise tile reader.
- Consumes IC_PAR-wide activation beats tagged first/last/channel-index.
- Fetches the matching IC_PAR weights for one output channel and accumulates across channel groups.
- Emits one signed ACC_W partial sum per pixel over a valid/ready handshake.

---
 rtl/pw_pkg.sv | 22 ++
 rtl/pw_dot_vec.sv | 25 ++
 rtl/pw_mac_accum_vec.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pw_pkg.sv
// rtl/pw_pkg.sv - shared widths, types and helpers for the pointwise MAC stage
package pw_pkg;

    localparam int DATA_W = 8;
    localparam int W_W    = 8;
    localparam int ACC_W  = 32;
    localparam int IC_PAR = 8;
    localparam int PROD_W = DATA_W + W_W;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Widen one lane product to accumulator width, preserving its sign.
    function automatic acc_t sext_prod(input logic signed [PROD_W-1:0] p);
        return acc_t'(p);
    endfunction

endpackage

// File: rtl/pw_dot_vec.sv
// rtl/pw_dot_vec.sv - combinational lane-masked signed dot product of one beat
// Disabled lanes contribute nothing, so tail beats of a pixel can carry junk.
module pw_dot_vec
    import pw_pkg::*;
(
    input  logic [IC_PAR*DATA_W-1:0] act_vec_i,
    input  logic [IC_PAR*W_W-1:0]    w_vec_i,
    input  logic [IC_PAR-1:0]        lane_en_i,
    output acc_t                     sum_o
);

    logic signed [PROD_W-1:0] prod;

    always_comb begin
        sum_o = '0;
        prod  = '0;
        for (int i = 0; i < IC_PAR; i++) begin
            prod = $signed(act_vec_i[i*DATA_W +: DATA_W]) * $signed(w_vec_i[i*W_W +: W_W]);
            if (lane_en_i[i]) begin
                sum_o = sum_o + sext_prod(prod);
            end
        end
    end

endmodule

// File: rtl/pw_mac_accum_vec.sv
// rtl/pw_mac_accum_vec.sv - pointwise conv MAC: beat accept, weight fetch, accumulate, emit
// Optional build macro PW_BIAS_EN seeds each pixel's accumulator with cfg_bias.
module pw_mac_accum_vec #(
    parameter int DATA_W = pw_pkg::DATA_W,
    parameter int W_W    = pw_pkg::W_W,
    parameter int ACC_W  = pw_pkg::ACC_W,
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16,
    parameter int IC_PAR = pw_pkg::IC_PAR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIM_W-1:0]         cfg_channels,
    input  logic [DIM_W-1:0]         cfg_pixels,
    input  logic [DIM_W-1:0]         cfg_oc_idx,
    input  logic [ADDR_W-1:0]        cfg_w_base_addr,
    input  logic [ACC_W-1:0]         cfg_bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IC_PAR*DATA_W-1:0] in_data_vec,
    input  logic                     in_first_ch,
    input  logic                     in_last_ch,
    input  logic [DIM_W-1:0]         in_ch_idx,
    output logic                     w_rd_en,
    output logic [ADDR_W-1:0]        w_rd_addr,
    input  logic [IC_PAR*W_W-1:0]    w_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_acc,
    output logic                     done
);

    import pw_pkg::*;

    localparam int CW = DIM_W + 1;

    state_t                   state_q, state_d;
    logic [DIM_W-1:0]         channels_q, channels_d;
    logic [DIM_W-1:0]         pixels_q, pixels_d;
    logic [DIM_W-1:0]         pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0]        row_base_q, row_base_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_first_q, s1_first_d;
    logic                     s1_last_q, s1_last_d;
    logic [DIM_W-1:0]         s1_ch_q, s1_ch_d;
    logic [IC_PAR*DATA_W-1:0] s1_data_q, s1_data_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic [ACC_W-1:0]         out_acc_q, out_acc_d;
    logic                     done_q, done_d;

    logic                     active;
    logic                     accept;
    logic                     out_fire;
    logic                     final_pix;
    logic [IC_PAR-1:0]        lane_en;
    acc_t                     dot_sum;
    logic signed [ACC_W-1:0]  acc_init;
    logic signed [ACC_W-1:0]  acc_new;

`ifdef PW_BIAS_EN
    logic [ACC_W-1:0]         bias_q, bias_d;
    assign acc_init = $signed(bias_q);
`else
    logic                     unused_bias;
    assign unused_bias = ^cfg_bias;
    assign acc_init    = '0;
`endif

    assign active = (state_q == ST_ACTIVE);

    // A pending last beat in stage 1 will claim the output register next
    // cycle, so hold off new beats until that result has been handed off.
    assign in_ready  = active && !start && (!out_valid_q || out_ready) && !(s1_valid_q && s1_last_q);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign final_pix = (pix_cnt_q + DIM_W'(1)) == pixels_q;

    assign w_rd_en   = accept;
    assign w_rd_addr = accept ? (row_base_q + ADDR_W'(in_ch_idx)) : '0;

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < IC_PAR; i++) begin
            lane_en[i] = ({1'b0, s1_ch_q} + CW'(i)) < {1'b0, channels_q};
        end
    end

    pw_dot_vec u_dot (
        .act_vec_i (s1_data_q),
        .w_vec_i   (w_rd_data),
        .lane_en_i (lane_en),
        .sum_o     (dot_sum)
    );

    assign acc_new = (s1_first_q ? acc_init : acc_q) + ACC_W'(dot_sum);

    always_comb begin
        state_d     = state_q;
        channels_d  = channels_q;
        pixels_d    = pixels_q;
        pix_cnt_d   = pix_cnt_q;
        row_base_d  = row_base_q;
        s1_valid_d  = accept;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_ch_d     = s1_ch_q;
        s1_data_d   = s1_data_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        done_d      = 1'b0;
`ifdef PW_BIAS_EN
        bias_d      = bias_q;
`endif

        if (accept) begin
            s1_first_d = in_first_ch;
            s1_last_d  = in_last_ch;
            s1_ch_d    = in_ch_idx;
            s1_data_d  = in_data_vec;
        end

        if (out_fire) begin
            out_valid_d = 1'b0;
            pix_cnt_d   = pix_cnt_q + DIM_W'(1);
            if (final_pix) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end

        if (s1_valid_q) begin
            acc_d = acc_new;
            if (s1_last_q) begin
                out_valid_d = 1'b1;
                out_acc_d   = acc_new;
            end
        end

        // Restart wins over everything in flight, including a pending output.
        if (start) begin
            state_d     = ST_ACTIVE;
            channels_d  = cfg_channels;
            pixels_d    = cfg_pixels;
            row_base_d  = cfg_w_base_addr + ADDR_W'(cfg_oc_idx) * ADDR_W'(cfg_channels);
            pix_cnt_d   = '0;
            s1_valid_d  = 1'b0;
            acc_d       = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
`ifdef PW_BIAS_EN
            bias_d      = cfg_bias;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            channels_q  <= '0;
            pixels_q    <= '0;
            pix_cnt_q   <= '0;
            row_base_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_ch_q     <= '0;
            s1_data_q   <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            done_q      <= 1'b0;
`ifdef PW_BIAS_EN
            bias_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            channels_q  <= channels_d;
            pixels_q    <= pixels_d;
            pix_cnt_q   <= pix_cnt_d;
            row_base_q  <= row_base_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_ch_q     <= s1_ch_d;
            s1_data_q   <= s1_data_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            done_q      <= done_d;
`ifdef PW_BIAS_EN
            bias_q      <= bias_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign done      = done_q;

endmodule
